// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall control unit.
package sail_hazard_pkg;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  // Encoding loaded into ID/EX when id_ex_bubble is set (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Source register depends on destination; x0 never matches.
  function automatic logic reg_dep(input logic used, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return used && (rd != 5'd0) && (rs == rd);
  endfunction
endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decode/EX/MEM hazard inputs and pipeline-register control outputs.
interface hazard_stall_unit_if #(parameter int CNT_W = 32);
  logic [4:0]       ID_rs1, ID_rs2;
  logic             ID_use_rs1, ID_use_rs2;
  logic             ID_CSRR;
  logic [11:0]      ID_CSR_Addr;
  logic [4:0]       EX_RegWriteAddr;
  logic             EX_RegWrite, EX_MemRead, EX_CSRW;
  logic [11:0]      EX_CSR_Addr;
  logic             MEM_MemAccess, dmem_ready, branch_flush;
  logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic             id_ex_bubble, if_id_flush, id_ex_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_CSRR, ID_CSR_Addr,
           EX_RegWriteAddr, EX_RegWrite, EX_MemRead, EX_CSRW, EX_CSR_Addr,
           MEM_MemAccess, dmem_ready, branch_flush,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           id_ex_bubble, if_id_flush, id_ex_flush, mem_timeout, stall_count
  );
  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_CSRR, ID_CSR_Addr,
           EX_RegWriteAddr, EX_RegWrite, EX_MemRead, EX_CSRW, EX_CSR_Addr,
           MEM_MemAccess, dmem_ready, branch_flush,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           id_ex_bubble, if_id_flush, id_ex_flush, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Up counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!clr_n)               q <= '0;
    else if (en && q != '1)   q <= q + W'(1);
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for hazards forwarding cannot cover:
// load-use, CSR read-after-write, and multi-cycle data-memory waits.
module hazard_stall_unit
  import sail_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard_stall_unit_if.slave  hif
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state;
  logic                pending_flush, mem_timeout;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    stall_q;
  logic                load_use, csr_haz, mem_hold, timed_out, wait_exit;
  logic                pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic                id_ex_bubble, flush;

  assign load_use = hif.EX_MemRead && hif.EX_RegWrite &&
                    (reg_dep(hif.ID_use_rs1, hif.ID_rs1, hif.EX_RegWriteAddr) ||
                     reg_dep(hif.ID_use_rs2, hif.ID_rs2, hif.EX_RegWriteAddr));
  assign csr_haz   = hif.ID_CSRR && hif.EX_CSRW && (hif.ID_CSR_Addr == hif.EX_CSR_Addr);
  assign mem_hold  = hif.MEM_MemAccess && !hif.dmem_ready;
  assign timed_out = (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign wait_exit = hif.dmem_ready || timed_out;

  always_comb begin
    pc_stall = 1'b0; if_id_stall = 1'b0; id_ex_stall = 1'b0; ex_mem_stall = 1'b0;
    id_ex_bubble = 1'b0; flush = 1'b0;
    if (rst) begin
      unique case (state)
        RUN: begin
          if (mem_hold) begin
            pc_stall = 1'b1; if_id_stall = 1'b1; id_ex_stall = 1'b1; ex_mem_stall = 1'b1;
          end else if (hif.branch_flush) begin
            flush = 1'b1;
          end else if (load_use || csr_haz) begin
            pc_stall = 1'b1; if_id_stall = 1'b1; id_ex_bubble = 1'b1;
          end
        end
        MEM_WAIT: begin
          // A branch resolving on the release cycle itself must not be lost.
          if (wait_exit) flush = pending_flush || hif.branch_flush;
          else begin
            pc_stall = 1'b1; if_id_stall = 1'b1; id_ex_stall = 1'b1; ex_mem_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      pending_flush <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      unique case (state)
        RUN: if (mem_hold) begin
          state         <= MEM_WAIT;
          pending_flush <= hif.branch_flush;
        end
        MEM_WAIT: if (wait_exit) begin
          state         <= RUN;
          pending_flush <= 1'b0;
          if (!hif.dmem_ready) mem_timeout <= 1'b1;
        end else begin
          pending_flush <= pending_flush || hif.branch_flush;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Wait counter runs only while EX/MEM is held, so it reads 1 on MEM_WAIT entry.
  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk(clk), .clr_n(rst && ex_mem_stall), .en(1'b1), .q(wait_cnt));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .clr_n(rst), .en(pc_stall), .q(stall_q));

  assign hif.pc_stall     = pc_stall;
  assign hif.if_id_stall  = if_id_stall;
  assign hif.id_ex_stall  = id_ex_stall;
  assign hif.ex_mem_stall = ex_mem_stall;
  assign hif.id_ex_bubble = id_ex_bubble;
  assign hif.if_id_flush  = flush;
  assign hif.id_ex_flush  = flush;
  assign hif.mem_timeout  = mem_timeout;
  assign hif.stall_count  = stall_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with MEM_TIMEOUT=8, CNT_W=4.
module tb_hazard_stall_unit;
  localparam int TO = 8;
  localparam int CW = 4;

  // control field order: pc, if_id_s, id_ex_s, ex_mem_s, bubble, if_id_f, id_ex_f
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] MEMS = 7'b1111000;
  localparam logic [6:0] FL   = 7'b0000011;

  typedef struct {
    string          tag;
    logic [7:0]     ctl;
    logic [CW-1:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          exp_to  = 1'b0;
  exp_t          sb[$];

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CNT_W(CW)) hif ();
  hazard_stall_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .hif(hif));

  task automatic clr_in();
    hif.ID_rs1 = '0; hif.ID_rs2 = '0; hif.ID_use_rs1 = 0; hif.ID_use_rs2 = 0;
    hif.ID_CSRR = 0; hif.ID_CSR_Addr = '0;
    hif.EX_RegWriteAddr = '0; hif.EX_RegWrite = 0; hif.EX_MemRead = 0;
    hif.EX_CSRW = 0; hif.EX_CSR_Addr = '0;
    hif.MEM_MemAccess = 0; hif.dmem_ready = 0; hif.branch_flush = 0;
  endtask

  task automatic set_lu();
    hif.EX_MemRead = 1; hif.EX_RegWrite = 1; hif.EX_RegWriteAddr = 5'd5;
    hif.ID_rs2 = 5'd5; hif.ID_use_rs2 = 1;
  endtask

  // One cycle: push expectation, sample mid-cycle, advance past the next edge.
  task automatic cyc(input string tag, input logic [6:0] ctl);
    exp_t e, g;
    logic [7:0] obs;
    e.tag = tag; e.ctl = {ctl, exp_to}; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    obs = {hif.pc_stall, hif.if_id_stall, hif.id_ex_stall, hif.ex_mem_stall,
           hif.id_ex_bubble, hif.if_id_flush, hif.id_ex_flush, hif.mem_timeout};
    n_checks++;
    assert (obs === g.ctl && hif.stall_count === g.cnt) else begin
      n_fail++;
      $error("FAIL %s: observed ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
             g.tag, obs, hif.stall_count, g.ctl, g.cnt);
    end
    if (ctl[6] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 0; clr_in();
    repeat (2) @(posedge clk); #1;
    set_lu();
    cyc("reset_gates_controls", NONE);
    rst = 1; clr_in();
    cyc("idle", NONE);

    set_lu();
    cyc("load_use", LU);
    hif.EX_MemRead = 0;
    cyc("load_use_one_cycle", NONE);

    set_lu(); hif.ID_use_rs2 = 0; hif.ID_rs1 = 5'd5;
    cyc("rs1_match_not_used", NONE);
    clr_in(); hif.EX_MemRead = 1; hif.EX_RegWrite = 1; hif.ID_use_rs1 = 1;
    cyc("x0_no_hazard", NONE);

    clr_in(); hif.EX_CSRW = 1; hif.EX_CSR_Addr = 12'h300;
    hif.ID_CSRR = 1; hif.ID_CSR_Addr = 12'h300;
    cyc("csr_raw", LU);
    hif.ID_CSR_Addr = 12'h301;
    cyc("csr_addr_differs", NONE);

    clr_in(); set_lu(); hif.branch_flush = 1;
    cyc("flush_beats_load_use", FL);

    clr_in(); hif.MEM_MemAccess = 1;
    cyc("mem_wait_c1", MEMS);
    hif.branch_flush = 1;
    cyc("mem_wait_c2_branch", MEMS);
    hif.branch_flush = 0; set_lu();
    cyc("mem_wait_c3_no_bubble", MEMS);
    clr_in(); hif.MEM_MemAccess = 1;
    cyc("mem_wait_c4", MEMS);
    hif.dmem_ready = 1;
    cyc("mem_release_flush", FL);
    clr_in();
    cyc("flush_single_cycle", NONE);

    hif.MEM_MemAccess = 1;
    for (int i = 0; i < TO; i++) cyc("timeout_wait", MEMS);
    cyc("timeout_release", NONE);
    exp_to = 1'b1;
    hif.MEM_MemAccess = 0;
    cyc("timeout_flag_set", NONE);
    cyc("timeout_sticky", NONE);

    set_lu();
    for (int i = 0; i < 6; i++) cyc("stall_count_saturate", LU);

    clr_in(); hif.MEM_MemAccess = 1; hif.branch_flush = 1;
    cyc("wait_before_reset", MEMS);
    hif.branch_flush = 0;
    cyc("wait_before_reset_2", MEMS);
    rst = 0;
    cyc("reset_mid_wait", NONE);
    exp_to = 1'b0; exp_cnt = '0;
    rst = 1; hif.MEM_MemAccess = 0; hif.dmem_ready = 1;
    cyc("after_reset_no_flush", NONE);
    hif.dmem_ready = 0;
    cyc("after_reset_idle", NONE);

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Producer-side counterpart to the core's forwarding logic. It detects hazards that forwarding cannot resolve: load-use, CSR read-after-write, and multi-cycle data-memory waits. For each it drives the stall, bubble and flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers. It sits beside the forwarding unit in sail-core, between the decode stage and the pipeline-register enables.

Parameters:
MEM_TIMEOUT, 256, max cycles in MEM_WAIT before the timeout error is raised (≥2)
CNT_W, 32, width of the saturating stall-cycle counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low
ID_rs1  in  5  rs1 of instruction in decode
ID_rs2  in  5  rs2 of instruction in decode
ID_use_rs1  in  1  decode instruction reads rs1
ID_use_rs2  in  1  decode instruction reads rs2
ID_CSRR  in  1  decode instruction reads a CSR
ID_CSR_Addr  in  12  CSR address read in decode
EX_RegWriteAddr  in  5  destination register of instruction in EX
EX_RegWrite  in  1  EX instruction writes a register
EX_MemRead  in  1  EX instruction is a load
EX_CSRW  in  1  EX instruction writes a CSR
EX_CSR_Addr  in  12  CSR address written in EX
MEM_MemAccess  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes the access this cycle
branch_flush  in  1  branch resolved mispredicted (1-cycle pulse)
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
id_ex_stall  out  1  hold ID/EX register
ex_mem_stall  out  1  hold EX/MEM register
id_ex_bubble  out  1  load NOP into ID/EX
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  clear ID/EX
mem_timeout  out  1  sticky error: MEM_WAIT exceeded MEM_TIMEOUT
stall_count  out  CNT_W  cycles with pc_stall=1, saturating

Behaviour:
- Reset (rst=0 at posedge): state=RUN, pending_flush=0, wait counter=0, mem_timeout=0, stall_count=0.
- Control outputs are combinational from state plus inputs. During reset cycles all controls are 0.
- States: RUN, MEM_WAIT.
- load_use = EX_MemRead & EX_RegWrite & EX_RegWriteAddr≠0 & ((ID_use_rs1 & ID_rs1==EX_RegWriteAddr) | (ID_use_rs2 & ID_rs2==EX_RegWriteAddr)).
- csr_haz = ID_CSRR & EX_CSRW & ID_CSR_Addr==EX_CSR_Addr.
- RUN, priority highest first:
  1. MEM_MemAccess & !dmem_ready: assert pc/if_id/id_ex/ex_mem stalls. No bubble. Latch branch_flush into pending_flush. Go to MEM_WAIT with wait counter=1.
  2. branch_flush: if_id_flush=1, id_ex_flush=1. No stall, even if load_use or csr_haz is true (the hazardous instruction is squashed).
  3. load_use | csr_haz: pc_stall=1, if_id_stall=1, id_ex_bubble=1 for exactly one cycle. The next cycle re-evaluates; the producer is then in MEM and forwarding covers it.
- MEM_WAIT:
  - All four stalls held. Bubble and flush are 0.
  - branch_flush arriving here ORs into pending_flush.
  - Wait counter increments each cycle.
  - On dmem_ready: stalls drop in that same cycle and state goes to RUN. If pending_flush=1, if_id_flush and id_ex_flush assert in that same cycle and pending_flush clears.
  - When the wait counter reaches MEM_TIMEOUT: set mem_timeout (sticky until reset) and return to RUN without dmem_ready, applying pending_flush as above.
- stall_count increments each cycle pc_stall=1 and saturates at all-ones.
- Register x0 never causes a hazard.
- Reset mid-MEM_WAIT aborts the wait and discards pending_flush.

Decomposition:
- Shared package sail_hazard_pkg holds the state enum (RUN, MEM_WAIT) and the NOP encoding constant used by the bubble mux.
- One sub-module: sat_counter (parameterised width, enable, synchronous active-low clear), used for both stall_count and the wait counter.

Test Plan:
- Load-use: EX lw x5 (EX_MemRead=1, EX_RegWrite=1, EX_RegWriteAddr=5); ID add with ID_rs2=5, ID_use_rs2=1 → pc_stall, if_id_stall and id_ex_bubble =1 for 1 cycle, then 0; stall_count=1.
- x0 and CSR: EX_RegWriteAddr=0 load with ID_rs1=0 → no stall. EX_CSRW=1, EX_CSR_Addr=0x300, ID_CSRR=1, ID_CSR_Addr=0x300 → one bubble cycle. With ID_CSR_Addr=0x301 → none.
- Flush priority: load_use and branch_flush in the same cycle → if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Memory wait with deferred flush: MEM_MemAccess=1, dmem_ready=0 for 4 cycles, branch_flush pulse on cycle 2 → all stalls =1 for 4 cycles, no flush. Cycle 5 (dmem_ready=1): stalls 0, both flushes =1 for one cycle.
- Timeout: MEM_TIMEOUT=8, dmem_ready held 0 → mem_timeout=1 after 8 cycles in wait, state RUN, mem_timeout stays 1 until rst=0.
- Reset and saturation: rst=0 during MEM_WAIT → all outputs 0 next cycle. With CNT_W=4, 20 stall cycles → stall_count=15.
